// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register sentinel, status codes and data width.
package y86_pkg;

  localparam int unsigned DATA_W = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register index meaning "no register"; never stored in the file.
  localparam logic [3:0] RNONE = 4'hF;

  // Two-bit status encoding; INS is not encodable and folds onto 0.
  localparam logic [1:0] SINS = 2'd0;
  localparam logic [1:0] SAOK = 2'd1;
  localparam logic [1:0] SHLT = 2'd2;
  localparam logic [1:0] SADR = 2'd3;

endpackage

// File: rtl/y86_w_pipe_reg.sv
// W pipeline register: reset > halted hold > stall hold > bubble (NOP) > load from M stage.
module y86_w_pipe_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_bubble,
  input  logic              i_halted,
  input  logic [1:0]        i_stat,
  input  logic [3:0]        i_icode,
  input  logic [3:0]        i_dste,
  input  logic [DATA_W-1:0] i_vale,
  input  logic [3:0]        i_dstm,
  input  logic [DATA_W-1:0] i_valm,
  output logic [1:0]        o_stat,
  output logic [3:0]        o_icode,
  output logic [3:0]        o_dste,
  output logic [DATA_W-1:0] o_vale,
  output logic [3:0]        o_dstm,
  output logic [DATA_W-1:0] o_valm
);
  import y86_pkg::INOP;
  import y86_pkg::RNONE;
  import y86_pkg::SAOK;

  logic [1:0]        r_stat;
  logic [3:0]        r_icode;
  logic [3:0]        r_dste;
  logic [DATA_W-1:0] r_vale;
  logic [3:0]        r_dstm;
  logic [DATA_W-1:0] r_valm;

  logic w_hold;
  assign w_hold = i_halted || i_stall;

  // W register update with reset/halt/stall/bubble priority.
  always_ff @(posedge clk) begin
    if (rst || (!w_hold && i_bubble)) begin
      r_stat  <= SAOK;
      r_icode <= INOP;
      r_dste  <= RNONE;
      r_vale  <= '0;
      r_dstm  <= RNONE;
      r_valm  <= '0;
    end else if (!w_hold) begin
      r_stat  <= i_stat;
      r_icode <= i_icode;
      r_dste  <= i_dste;
      r_vale  <= i_vale;
      r_dstm  <= i_dstm;
      r_valm  <= i_valm;
    end
  end

  assign o_stat  = r_stat;
  assign o_icode = r_icode;
  assign o_dste  = r_dste;
  assign o_vale  = r_vale;
  assign o_dstm  = r_dstm;
  assign o_valm  = r_valm;

endmodule

// File: rtl/y86_writeback_regfile.sv
// Y86-64 writeback stage: W pipeline register, 15-entry register file, sticky halt.
// Optional macro Y86_RF_BYPASS_EN: reads matching an active commit return the value being written.
module y86_writeback_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_stall,
  input  logic              w_bubble,
  input  logic [1:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [3:0]        W_icode,
  output logic [3:0]        W_dstE,
  output logic [DATA_W-1:0] W_valE,
  output logic [3:0]        W_dstM,
  output logic [DATA_W-1:0] W_valM,
  output logic [1:0]        W_stat,
  output logic              halted
);
  import y86_pkg::RNONE;
  import y86_pkg::SAOK;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_halted;

  logic w_commit_ok;
  logic w_we_e;
  logic w_we_m;

  y86_w_pipe_reg #(
    .DATA_W (DATA_W)
  ) u_w_pipe_reg (
    .clk      (clk),
    .rst      (rst),
    .i_stall  (w_stall),
    .i_bubble (w_bubble),
    .i_halted (r_halted),
    .i_stat   (m_stat),
    .i_icode  (m_icode),
    .i_dste   (m_dstE),
    .i_vale   (m_valE),
    .i_dstm   (m_dstM),
    .i_valm   (m_valM),
    .o_stat   (W_stat),
    .o_icode  (W_icode),
    .o_dste   (W_dstE),
    .o_vale   (W_valE),
    .o_dstm   (W_dstM),
    .o_valm   (W_valM)
  );

  // A faulting W instruction never commits; once halted nothing commits until reset.
  assign w_commit_ok = !rst && (W_stat == SAOK) && !r_halted;
  assign w_we_e      = w_commit_ok && (W_dstE != RNONE);
  assign w_we_m      = w_commit_ok && (W_dstM != RNONE);

  // Register file commit; valM wins when both ports target the same register (popq %rsp).
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREGS); i++) begin
      if (rst) begin
        r_regs[i] <= '0;
      end else if (w_we_m && (W_dstM == 4'(i))) begin
        r_regs[i] <= W_valM;
      end else if (w_we_e && (W_dstE == 4'(i))) begin
        r_regs[i] <= W_valE;
      end
    end
  end

  // Sticky halt: set the edge after a non-AOK status sits in W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (W_stat != SAOK) begin
      r_halted <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx != RNONE) begin
`ifdef Y86_RF_BYPASS_EN
      if (w_we_m && (W_dstM == idx)) begin
        val = W_valM;
      end else if (w_we_e && (W_dstE == idx)) begin
        val = W_valE;
      end else begin
        val = r_regs[idx];
      end
`else
      val = r_regs[idx];
`endif
    end
    return val;
  endfunction

  // Combinational decode-stage read ports.
  always_comb begin
    d_rvalA = read_port(d_srcA);
    d_rvalB = read_port(d_srcB);
  end

  assign halted = r_halted;

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Directed bench for y86_writeback_regfile; expected values are queued when stimulus is driven
// and popped at the matching comparison.
module tb_y86_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_stall;
  logic        w_bubble;
  logic [1:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic [1:0]  W_stat;
  logic        halted;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  y86_writeback_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .w_stall  (w_stall),
    .w_bubble (w_bubble),
    .m_stat   (m_stat),
    .m_icode  (m_icode),
    .m_valE   (m_valE),
    .m_valM   (m_valM),
    .m_dstE   (m_dstE),
    .m_dstM   (m_dstM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_rvalA  (d_rvalA),
    .d_rvalB  (d_rvalB),
    .W_icode  (W_icode),
    .W_dstE   (W_dstE),
    .W_valE   (W_valE),
    .W_dstM   (W_dstM),
    .W_valM   (W_valM),
    .W_stat   (W_stat),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    exp = sb.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] de,
                         input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    m_stat  = st;
    m_icode = ic;
    m_dstE  = de;
    m_valE  = ve;
    m_dstM  = dm;
    m_valM  = vm;
  endtask

  task automatic drive_nop();
    drive_m(2'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  task automatic read_a(input logic [3:0] idx);
    d_srcA = idx;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    w_stall = 1'b0;
    w_bubble = 1'b0;
    d_srcA = 4'h0;
    d_srcB = 4'hF;
    drive_nop();
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    expect_val(64'h1); check("rst_W_icode", 64'(W_icode));
    expect_val(64'hF); check("rst_W_dstE", 64'(W_dstE));
    expect_val(64'hF); check("rst_W_dstM", 64'(W_dstM));
    expect_val(64'h0); check("rst_W_valE", W_valE);
    expect_val(64'h1); check("rst_W_stat", 64'(W_stat));
    expect_val(64'h0); check("rst_halted", 64'(halted));
    read_a(4'h0);
    expect_val(64'h0); check("rst_reg0", d_rvalA);

    // Simple valE write to r3.
    drive_m(2'd1, 4'h6, 4'h3, 64'h1234, 4'hF, 64'h0);
    tick();
    expect_val(64'h3); check("w_latch_dstE", 64'(W_dstE));
    expect_val(64'h1234); check("w_latch_valE", W_valE);
    drive_nop();
    tick();
    read_a(4'h3);
    expect_val(64'h1234); check("reg3_write", d_rvalA);
    expect_val(64'h0); check("srcB_none", d_rvalB);

    // popq %rsp style: both ports to r4, valM wins.
    drive_m(2'd1, 4'hB, 4'h4, 64'h10, 4'h4, 64'h20);
    tick();
    expect_val(64'h20); check("w_latch_valM", W_valM);
    drive_nop();
    tick();
    read_a(4'h4);
    expect_val(64'h20); check("reg4_valM_wins", d_rvalA);

    // Commit-cycle read of r6: bypass returns new value, otherwise old value.
    drive_m(2'd1, 4'h3, 4'h6, 64'h55, 4'hF, 64'h0);
    tick();
    drive_nop();
    read_a(4'h6);
`ifdef Y86_RF_BYPASS_EN
    expect_val(64'h55);
`else
    expect_val(64'h0);
`endif
    check("reg6_commit_cycle", d_rvalA);
    tick();
    read_a(4'h6);
    expect_val(64'h55); check("reg6_after", d_rvalA);

    // Stall + bubble together: W holds, stalled entry re-commits, new entry ignored.
    drive_m(2'd1, 4'h3, 4'h7, 64'h77, 4'hF, 64'h0);
    tick();
    w_stall = 1'b1;
    w_bubble = 1'b1;
    drive_m(2'd1, 4'h3, 4'h8, 64'h88, 4'hF, 64'h0);
    tick();
    expect_val(64'h7); check("stall_W_dstE", 64'(W_dstE));
    expect_val(64'h77); check("stall_W_valE", W_valE);
    read_a(4'h8);
    expect_val(64'h0); check("stall_reg8", d_rvalA);
    read_a(4'h7);
    expect_val(64'h77); check("stall_reg7", d_rvalA);
    w_stall = 1'b0;
    tick();
    expect_val(64'h1); check("bubble_W_icode", 64'(W_icode));
    expect_val(64'hF); check("bubble_W_dstE", 64'(W_dstE));
    read_a(4'h8);
    expect_val(64'h0); check("bubble_reg8", d_rvalA);
    w_bubble = 1'b0;
    drive_nop();
    tick();

    // Halt status: no commit, sticky halt, later inputs ignored.
    drive_m(2'd2, 4'h0, 4'h5, 64'h7, 4'hF, 64'h0);
    tick();
    expect_val(64'h2); check("halt_W_stat", 64'(W_stat));
    expect_val(64'h0); check("halt_not_yet", 64'(halted));
    tick();
    expect_val(64'h1); check("halted_set", 64'(halted));
    read_a(4'h5);
    expect_val(64'h0); check("halt_reg5", d_rvalA);
    drive_m(2'd1, 4'h3, 4'h9, 64'h99, 4'hF, 64'h0);
    tick();
    tick();
    expect_val(64'h5); check("halt_W_hold_dstE", 64'(W_dstE));
    expect_val(64'h2); check("halt_W_hold_stat", 64'(W_stat));
    expect_val(64'h1); check("halted_sticky", 64'(halted));
    read_a(4'h9);
    expect_val(64'h0); check("halt_reg9", d_rvalA);

    // Reset clears halt; then reset mid-stream with a pending r2 write.
    rst = 1'b1;
    drive_nop();
    tick();
    rst = 1'b0;
    expect_val(64'h0); check("halted_cleared", 64'(halted));
    drive_m(2'd1, 4'h3, 4'h2, 64'h22, 4'hF, 64'h0);
    tick();
    expect_val(64'h2); check("pend_W_dstE", 64'(W_dstE));
    rst = 1'b1;
    drive_nop();
    tick();
    expect_val(64'hF); check("midrst_W_dstE", 64'(W_dstE));
    expect_val(64'h0); check("midrst_W_valE", W_valE);
    read_a(4'h2);
    expect_val(64'h0); check("midrst_reg2", d_rvalA);
    read_a(4'h3);
    expect_val(64'h0); check("midrst_reg3", d_rvalA);
    rst = 1'b0;
    tick();
    read_a(4'h2);
    expect_val(64'h0); check("after_rst_reg2", d_rvalA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
